// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter family.
// FSM state encoding and the source-index width calculation.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  // Index width for a given input count; never collapses to zero bits.
  function automatic int calc_src_bits(input int num_inputs);
    if (num_inputs <= 1) return 1;
    return $clog2(num_inputs);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after last_grant+1.
// Returns the winner as index and one-hot, plus an any-request flag.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [N-1:0]     o_grant_oh,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  logic [2*N-1:0] w_req2;
  logic [2*N-1:0] w_rot;
  logic [N-1:0]   w_rot_n;
  logic [IDX_W:0] w_shift;
  logic [IDX_W:0] w_off;
  logic [IDX_W+1:0] w_sum;

  // Rotating a doubled request vector puts the highest-priority requester at bit 0.
  assign w_req2  = {i_req, i_req};
  assign w_shift = {1'b0, i_last_grant} + (IDX_W+1)'(1);
  assign w_rot   = w_req2 >> w_shift;
  assign w_rot_n = w_rot[N-1:0];
  assign o_any   = |i_req;

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot_n[i]) w_off = (IDX_W+1)'(i);
    end
    w_sum = {1'b0, w_shift} + {1'b0, w_off};
    if (w_sum >= (IDX_W+2)'(N)) w_sum = w_sum - (IDX_W+2)'(N);
    o_grant_idx = w_sum[IDX_W-1:0];
    o_grant_oh  = '0;
    o_grant_oh[o_grant_idx] = o_any;
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI stream between NUM_INPUTS sources.
// Optional axis_o_src tag output enabled by AXIS_PACKET_ARBITER_SRC_TAG_EN.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS     = 2,
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  localparam int SRC_BITS      = calc_src_bits(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
  output logic [NUM_INPUTS-1:0]                axis_i_tready,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
  output logic                                 axis_o_tvalid,
  input  logic                                 axis_o_tready,
  output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
  output logic [AXIS_BYTES-1:0]                axis_o_tkeep,
  output logic                                 axis_o_tlast,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser
`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
  ,
  output logic [SRC_BITS-1:0]                  axis_o_src
`endif
);

  localparam int DATA_W = AXIS_BYTES * 8;

  arb_state_e            r_state;
  logic [SRC_BITS-1:0]   r_grant;
  logic [SRC_BITS-1:0]   r_last_grant;
  logic [NUM_INPUTS-1:0] r_grant_oh;

  logic [NUM_INPUTS-1:0] w_win_oh;
  logic [SRC_BITS-1:0]   w_win_idx;
  logic                  w_win_any;
  logic                  w_pkt_done;

  rr_arbiter #(
    .N     (NUM_INPUTS),
    .IDX_W (SRC_BITS)
  ) u_rr (
    .i_req        (axis_i_tvalid),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_win_oh),
    .o_grant_idx  (w_win_idx),
    .o_any        (w_win_any)
  );

  assign w_pkt_done = (r_state == PASS) && axis_o_tvalid && axis_o_tready && axis_o_tlast;

  // Grant is only re-evaluated in IDLE, so a packet can never be interleaved.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_last_grant <= SRC_BITS'(NUM_INPUTS - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_win_any) begin
            r_state    <= PASS;
            r_grant    <= w_win_idx;
            r_grant_oh <= w_win_oh;
          end
        end
        PASS: begin
          if (w_pkt_done) begin
            r_state      <= IDLE;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pure mux datapath: no register between granted input and output.
  always_comb begin
    axis_o_tvalid = 1'b0;
    axis_o_tdata  = '0;
    axis_o_tkeep  = '0;
    axis_o_tlast  = 1'b0;
    axis_o_tuser  = '0;
    axis_i_tready = '0;
    if (r_state == PASS) begin
      axis_i_tready = r_grant_oh & {NUM_INPUTS{axis_o_tready}};
      for (int n = 0; n < NUM_INPUTS; n++) begin
        if (r_grant == SRC_BITS'(n)) begin
          axis_o_tvalid = axis_i_tvalid[n];
          axis_o_tdata  = axis_i_tdata[n*DATA_W +: DATA_W];
          axis_o_tkeep  = axis_i_tkeep[n*AXIS_BYTES +: AXIS_BYTES];
          axis_o_tlast  = axis_i_tlast[n];
          axis_o_tuser  = axis_i_tuser[n*AXIS_USER_BITS +: AXIS_USER_BITS];
        end
      end
    end
  end

`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
  // r_grant only changes on IDLE->PASS, so it is stable per packet and holds in IDLE.
  assign axis_o_src = r_grant;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: vector table plus scoreboarded sequences.
`timescale 1ns/1ps
module tb_axis_packet_arbiter;

`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif
  localparam int SB = (N <= 1) ? 1 : $clog2(N);

  logic           clk;
  logic           aresetn;
  logic [N-1:0]   axis_i_tvalid;
  logic [N-1:0]   axis_i_tready;
  logic [N*8-1:0] axis_i_tdata;
  logic [N-1:0]   axis_i_tkeep;
  logic [N-1:0]   axis_i_tlast;
  logic [N-1:0]   axis_i_tuser;
  logic           axis_o_tvalid;
  logic           axis_o_tready;
  logic [7:0]     axis_o_tdata;
  logic [0:0]     axis_o_tkeep;
  logic           axis_o_tlast;
  logic [0:0]     axis_o_tuser;
`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
  logic [SB-1:0]  axis_o_src;
`endif

  axis_packet_arbiter #(
    .NUM_INPUTS     (N),
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (1)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tready (axis_i_tready),
    .axis_i_tdata  (axis_i_tdata),
    .axis_i_tkeep  (axis_i_tkeep),
    .axis_i_tlast  (axis_i_tlast),
    .axis_i_tuser  (axis_i_tuser),
    .axis_o_tvalid (axis_o_tvalid),
    .axis_o_tready (axis_o_tready),
    .axis_o_tdata  (axis_o_tdata),
    .axis_o_tkeep  (axis_o_tkeep),
    .axis_o_tlast  (axis_o_tlast),
    .axis_o_tuser  (axis_o_tuser)
`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
    ,
    .axis_o_src    (axis_o_src)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [1:0] tv;
    logic [7:0] d0;
    logic       l0;
    logic [7:0] d1;
    logic       l1;
    logic [1:0] exp_rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_l;
  } vec_t;

  beat_t  src_q[N][$];
  beat_t  exp_q[$];
  logic [N-1:0] hold;
  logic   bubble_chk;
  logic   src_chk;
  int     exp_src;
  int     errors;
  int     checks;
  vec_t   vecs[9];

  function automatic logic kp(input logic [7:0] d);
    return d[1];
  endfunction

  function automatic logic us(input logic [7:0] d);
    return d[0];
  endfunction

  function automatic beat_t mk(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_srcs();
    beat_t b;
    axis_i_tvalid = '0;
    axis_i_tdata  = '0;
    axis_i_tkeep  = '0;
    axis_i_tlast  = '0;
    axis_i_tuser  = '0;
    for (int n = 0; n < N; n++) begin
      if (src_q[n].size() > 0 && !hold[n]) begin
        b = src_q[n][0];
        axis_i_tvalid[n]       = 1'b1;
        axis_i_tdata[n*8 +: 8] = b.data;
        axis_i_tkeep[n]        = kp(b.data);
        axis_i_tlast[n]        = b.last;
        axis_i_tuser[n]        = us(b.data);
      end
    end
  endtask

  // One clock: drive at posedge+1, check mid-cycle, consume handshakes after the edge.
  task automatic tick();
    logic [N-1:0] hs;
    beat_t e;
    drive_srcs();
    #3;
    if (axis_o_tvalid && axis_o_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(axis_o_tdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({axis_o_tdata, axis_o_tkeep, axis_o_tlast, axis_o_tuser}),
              32'({e.data, kp(e.data), e.last, us(e.data)}));
      end
`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
      if (src_chk) check("src_tag", 32'(axis_o_src), 32'(exp_src));
`endif
    end
    check("rdy_gated", 32'(axis_i_tready & ~{N{axis_o_tready}}), 0);
    if (bubble_chk) begin
      check("bubble_rdy1", 32'(axis_i_tready[1]), 0);
      check("bubble_ov", 32'(axis_o_tvalid), 0);
    end
    hs = axis_i_tvalid & axis_i_tready;
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) begin
      if (hs[n]) void'(src_q[n].pop_front());
    end
  endtask

  task automatic run_until_empty(input int budget);
    int cnt;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < budget) begin
      tick();
      cnt++;
    end
    check("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    hold = '0;
    bubble_chk = 1'b0;
    src_chk = 1'b0;
    exp_src = 0;
    aresetn = 1'b0;
    axis_o_tready = 1'b1;
    drive_srcs();

    //            tv     d0    l0    d1    l1    rdy    v     d     l
    vecs[0] = '{2'b11, 8'h10, 1'b0, 8'h20, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{2'b11, 8'h10, 1'b0, 8'h20, 1'b0, 2'b01, 1'b1, 8'h10, 1'b0};
    vecs[2] = '{2'b11, 8'h11, 1'b0, 8'h20, 1'b0, 2'b01, 1'b1, 8'h11, 1'b0};
    vecs[3] = '{2'b11, 8'h12, 1'b1, 8'h20, 1'b0, 2'b01, 1'b1, 8'h12, 1'b1};
    vecs[4] = '{2'b10, 8'h00, 1'b0, 8'h20, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{2'b10, 8'h00, 1'b0, 8'h20, 1'b0, 2'b10, 1'b1, 8'h20, 1'b0};
    vecs[6] = '{2'b10, 8'h00, 1'b0, 8'h21, 1'b0, 2'b10, 1'b1, 8'h21, 1'b0};
    vecs[7] = '{2'b10, 8'h00, 1'b0, 8'h22, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1};
    vecs[8] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 32'(axis_o_tvalid), 0);
    check("rst_rdy", 32'(axis_i_tready), 0);
`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
    check("rst_src", 32'(axis_o_src), 0);
`endif

    // Reset release with inputs 0 and 1 both carrying 3-beat packets.
    aresetn = 1'b1;
    for (int r = 0; r < 9; r++) begin
      axis_i_tvalid = '0;
      axis_i_tdata  = '0;
      axis_i_tkeep  = '0;
      axis_i_tlast  = '0;
      axis_i_tuser  = '0;
      axis_i_tvalid[1:0] = vecs[r].tv;
      axis_i_tdata[7:0]  = vecs[r].d0;
      axis_i_tdata[15:8] = vecs[r].d1;
      axis_i_tlast[0]    = vecs[r].l0;
      axis_i_tlast[1]    = vecs[r].l1;
      axis_i_tkeep[0]    = kp(vecs[r].d0);
      axis_i_tkeep[1]    = kp(vecs[r].d1);
      axis_i_tuser[0]    = us(vecs[r].d0);
      axis_i_tuser[1]    = us(vecs[r].d1);
      #3;
      check("tbl_ov", 32'(axis_o_tvalid), 32'(vecs[r].exp_v));
      check("tbl_rdy", 32'(axis_i_tready), 32'(vecs[r].exp_rdy));
      if (vecs[r].exp_v) begin
        check("tbl_data", 32'(axis_o_tdata), 32'(vecs[r].exp_d));
        check("tbl_last", 32'(axis_o_tlast), 32'(vecs[r].exp_l));
      end
      @(posedge clk);
      #1;
    end

    // Input 1 streams single-beat packets; input 0 joins and must win the next IDLE.
    for (int k = 0; k < 4; k++) src_q[1].push_back(mk(8'h30 + 8'(k), 1'b1));
    exp_q.push_back(mk(8'h30, 1'b1));
    exp_q.push_back(mk(8'h31, 1'b1));
    exp_q.push_back(mk(8'h40, 1'b1));
    exp_q.push_back(mk(8'h32, 1'b1));
    exp_q.push_back(mk(8'h33, 1'b1));
    repeat (4) tick();
    src_q[0].push_back(mk(8'h40, 1'b1));
    run_until_empty(30);

    // Mid-packet bubble on the granted input must not release the grant.
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(mk(8'h50 + 8'(k), k == 3));
      exp_q.push_back(mk(8'h50 + 8'(k), k == 3));
    end
    src_q[1].push_back(mk(8'h60, 1'b1));
    exp_q.push_back(mk(8'h60, 1'b1));
    repeat (3) tick();
    hold[0] = 1'b1;
    bubble_chk = 1'b1;
    repeat (5) tick();
    hold[0] = 1'b0;
    bubble_chk = 1'b0;
    run_until_empty(30);

    // Downstream back-pressure alternating during a 4-beat packet.
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(mk(8'hA0 + 8'(k), k == 3));
      exp_q.push_back(mk(8'hA0 + 8'(k), k == 3));
    end
    for (int k = 0; k < 24 && exp_q.size() > 0; k++) begin
      axis_o_tready = k[0];
      tick();
    end
    check("bp_drain", 32'(exp_q.size()), 0);
    axis_o_tready = 1'b1;

    // Asynchronous reset during beat 2 of 4; afterwards input 0 has priority again.
    for (int k = 0; k < 4; k++) src_q[0].push_back(mk(8'hB0 + 8'(k), k == 3));
    exp_q.push_back(mk(8'hB0, 1'b0));
    repeat (2) tick();
    drive_srcs();
    #2;
    check("pre_rst_ov", 32'(axis_o_tvalid), 1);
    aresetn = 1'b0;
    #1;
    check("async_rst_ov", 32'(axis_o_tvalid), 0);
    check("async_rst_rdy", 32'(axis_i_tready), 0);
    src_q[0].delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    src_q[0].push_back(mk(8'hD0, 1'b1));
    src_q[1].push_back(mk(8'hE0, 1'b1));
    exp_q.push_back(mk(8'hD0, 1'b1));
    exp_q.push_back(mk(8'hE0, 1'b1));
    run_until_empty(20);

`ifdef AXIS_PACKET_ARBITER_SRC_TAG_EN
    // Only input 3 requesting: every beat tagged with source 3, tag held afterwards.
    for (int k = 0; k < 3; k++) begin
      src_q[3].push_back(mk(8'hF0 + 8'(k), k == 2));
      exp_q.push_back(mk(8'hF0 + 8'(k), k == 2));
    end
    src_chk = 1'b1;
    exp_src = 3;
    run_until_empty(20);
    src_chk = 1'b0;
    tick();
    check("src_hold_idle", 32'(axis_o_src), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
